// File: rtl/mssi_sync_pkg.sv
// mssi_sync_pkg: shared FSM state type and sizing helpers for the MSSI sync generator.
//   mssi_state_t : IDLE / ARMED / RUN
//   cnt_w()      : run counter width, max(DLY_W, WID_W) + 1, so it holds max delay + width
//   max_delay()  : largest field in a packed delay vector (up to 512 bits, fields up to 31 bits)
package mssi_sync_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, RUN} mssi_state_t;
  function automatic int cnt_w(input int dly_w, input int wid_w);
    return (dly_w > wid_w ? dly_w : wid_w) + 1;
  endfunction
  function automatic logic [31:0] max_delay(input logic [511:0] v, input int n, input int w);
    logic [31:0] m;
    logic [31:0] x;
    m = '0;
    for (int i = 0; i < n; i++) begin
      x = 32'(v >> (i * w)) & ((32'd1 << w) - 32'd1);
      m = x > m ? x : m;
    end
    return m;
  endfunction
endpackage

// File: rtl/mssi_sync_chan.sv
// mssi_sync_chan: one sync channel - latched delay, window compare and registered sync output.
//   clk, resetn : clock, async active-low reset
//   load        : latch cfg_delay (arm edge)
//   cfg_delay   : this channel's delay in cycles
//   wid         : shared latched pulse width
//   cnt         : shared run counter
//   en          : counter value is valid this cycle (running, not aborting)
//   sync        : high while delay <= cnt < delay + wid, one cycle after the compare
module mssi_sync_chan
  import mssi_sync_pkg::*;
#(
  parameter int DLY_W = 8,
  parameter int WID_W = 8,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [DLY_W-1:0] cfg_delay,
  input  logic [WID_W-1:0] wid,
  input  logic [CNT_W-1:0] cnt,
  input  logic             en,
  output logic             sync
);
  logic [DLY_W-1:0] dly;
  logic [CNT_W-1:0] lo;
  logic [CNT_W-1:0] hi;
  assign lo = CNT_W'(dly);
  assign hi = lo + CNT_W'(wid);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      dly  <= '0;
      sync <= 1'b0;
    end else begin
      if (load) dly <= cfg_delay;
      sync <= en && cnt >= lo && cnt < hi;
    end
endmodule

// File: rtl/mssi_sync_gen.sv
// mssi_sync_gen: multi-channel MSSI sync pulse generator (arm -> trigger -> timed pulses -> done).
//   clk, resetn : clock, async active-low reset
//   cfg_delay   : per-channel delay, channel i = [i*DLY_W +: DLY_W], latched on arm
//   cfg_width   : shared pulse width in cycles (0 = no pulse), latched on arm
//   arm         : latch config, enter/stay ARMED
//   trigger     : start a run (level, sampled in ARMED)
//   abort       : return to IDLE from any state, wins over arm/trigger
//   ext_trig    : async external trigger, only with MSSI_SYNC_EXT_TRIG_EN defined
//   sync_out    : registered sync pulses
//   armed, busy : ARMED / RUN indicators
//   done        : one-cycle pulse when a run completes (not on abort)
// Build option MSSI_SYNC_EXT_TRIG_EN adds ext_trig through a 2-FF synchronizer and edge detect.
module mssi_sync_gen
  import mssi_sync_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DLY_W  = 8,
  parameter int WID_W  = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NUM_CH*DLY_W-1:0] cfg_delay,
  input  logic [WID_W-1:0]        cfg_width,
  input  logic                    arm,
  input  logic                    trigger,
  input  logic                    abort,
`ifdef MSSI_SYNC_EXT_TRIG_EN
  input  logic                    ext_trig,
`endif
  output logic [NUM_CH-1:0]       sync_out,
  output logic                    armed,
  output logic                    busy,
  output logic                    done
);
  localparam int CNT_W = cnt_w(DLY_W, WID_W);
  mssi_state_t state, nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] end_cnt;
  logic [CNT_W-1:0] new_end;
  logic [WID_W-1:0] wid;
  logic load;
  logic start;
  logic fin;
  logic trig;
  logic en;
  assign new_end = CNT_W'(max_delay(512'(cfg_delay), NUM_CH, DLY_W)) + CNT_W'(cfg_width);
`ifdef MSSI_SYNC_EXT_TRIG_EN
  logic [2:0] ext_sr;
  logic ext_pulse;
  // two sync stages, a history stage for edge detect, and a registered pulse: 3 cycles total
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      ext_sr    <= '0;
      ext_pulse <= 1'b0;
    end else begin
      ext_sr    <= {ext_sr[1:0], ext_trig};
      ext_pulse <= ext_sr[1] & ~ext_sr[2];
    end
  assign trig = trigger | ext_pulse;
`else
  assign trig = trigger;
`endif
  always_comb begin
    nxt   = state;
    load  = 1'b0;
    start = 1'b0;
    fin   = 1'b0;
    if (abort) nxt = IDLE;
    else
      case (state)
        IDLE: begin
          load = arm;
          nxt  = arm ? ARMED : IDLE;
        end
        ARMED: begin
          load  = arm;
          start = !arm && trig;
          nxt   = start ? RUN : ARMED;
        end
        RUN: begin
          fin = busy && cnt == end_cnt;
          nxt = fin ? IDLE : RUN;
        end
        default: nxt = IDLE;
      endcase
  end
  // the first RUN cycle only loads the pipeline; counting starts once busy is up,
  // which places every output two edges after the counter value it reflects
  assign en = busy & ~abort;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      end_cnt <= '0;
      wid     <= '0;
      busy    <= 1'b0;
      armed   <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= nxt;
      busy  <= state == RUN && nxt == RUN;
      armed <= nxt == ARMED;
      done  <= fin;
      cnt   <= start ? '0 : busy ? cnt + CNT_W'(1) : cnt;
      if (load) begin
        wid     <= cfg_width;
        end_cnt <= new_end;
      end
    end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mssi_sync_chan #(
      .DLY_W(DLY_W),
      .WID_W(WID_W),
      .CNT_W(CNT_W)
    ) u_ch (
      .clk      (clk),
      .resetn   (resetn),
      .load     (load),
      .cfg_delay(cfg_delay[i*DLY_W +: DLY_W]),
      .wid      (wid),
      .cnt      (cnt),
      .en       (en),
      .sync     (sync_out[i])
    );
  end
endmodule

// File: tb/tb_mssi_sync_gen.sv
// tb_mssi_sync_gen: scoreboard bench; expected output-change events are pushed per sequence, a monitor pops and compares.
module tb_mssi_sync_gen;
  localparam int NUM_CH = 2;
  localparam int DLY_W = 8;
  localparam int WID_W = 8;
  localparam int NEVER = 32'h3fff_ffff;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic arm = 1'b0;
  logic trigger = 1'b0;
  logic abort = 1'b0;
  logic [NUM_CH*DLY_W-1:0] cfg_delay = '0;
  logic [WID_W-1:0] cfg_width = '0;
`ifdef MSSI_SYNC_EXT_TRIG_EN
  logic ext_trig = 1'b0;
`endif
  logic [NUM_CH-1:0] sync_out;
  logic armed, busy, done;
  typedef struct {
    int e;
    logic [4:0] v;
  } ev_t;
  ev_t q[$];
  ev_t mev;
  logic [4:0] mv;
  logic [4:0] prev = '0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  mssi_sync_gen #(.NUM_CH(NUM_CH), .DLY_W(DLY_W), .WID_W(WID_W)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .cfg_delay(cfg_delay),
    .cfg_width(cfg_width),
    .arm      (arm),
    .trigger  (trigger),
    .abort    (abort),
`ifdef MSSI_SYNC_EXT_TRIG_EN
    .ext_trig (ext_trig),
`endif
    .sync_out (sync_out),
    .armed    (armed),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, req, cyc);
    end
  endtask

  // expected {done, busy, armed, sync[1:0]} after edge e, from the timing rules:
  // run triggered at edge t, abort sampled at edge a, second arming only in the ext scenario
  function automatic logic [4:0] expv(input int e, input int ea, input int t, input int a,
                                      input int d0, input int d1, input int w, input int endc,
                                      input bit ext);
    bit ran;
    logic [4:0] v;
    ran = a > t;
    v[0] = ran && e >= t + d0 + 2 && e < t + d0 + w + 2 && e < a;
    v[1] = ran && e >= t + d1 + 2 && e < t + d1 + w + 2 && e < a;
    v[2] = (e >= ea && e < t && e < a) || (ext && e >= ea + 20 && e < a);
    v[3] = ran && e >= t + 1 && e < t + endc + 2 && e < a;
    v[4] = ran && e == t + endc + 2 && a > t + endc + 2;
    return v;
  endfunction

  always @(negedge clk)
    if (mon_en && resetn) begin
      mv = {done, busy, armed, sync_out};
      if (mv != prev || done) begin
        if (q.size() == 0) chk("unexpected output event", int'(mv), -1);
        else begin
          mev = q.pop_front();
          chk("event edge", cyc, mev.e);
          chk("event outputs", int'(mv), int'(mev.v));
        end
      end
      prev = mv;
    end

  task automatic run_seq(input logic [15:0] dl, input int w, input int gap, input int abort_rel,
                         input bit noise, input bit use_ext);
    int d0, d1, ea, t, a, endc, last, e, rend;
    logic [4:0] pv, v;
    d0 = int'(dl[7:0]);
    d1 = int'(dl[15:8]);
    endc = (d0 > d1 ? d0 : d1) + w;
    @(negedge clk);
    if (noise) begin
      trigger = 1'b1;
      repeat (2) @(negedge clk);
      trigger = 1'b0;
    end
    ea = cyc + 1;
    t = use_ext ? ea + 4 : ea + 1 + gap;
    a = abort_rel < 0 ? NEVER : ea + abort_rel;
    last = t + endc + 3;
    if (use_ext && last < ea + 45) last = ea + 45;
    if (a != NEVER && a + 1 > last) last = a + 1;
    rend = a < t + endc + 2 ? a : t + endc + 2;
    pv = '0;
    for (e = ea; e <= last; e++) begin
      v = expv(e, ea, t, a, d0, d1, w, endc, use_ext);
      if (v != pv || v[4]) q.push_back('{e, v});
      pv = v;
    end
    for (int r = 0; r <= last - ea; r++) begin
      e = ea + r;
      arm = r == 0 || (r == 1 && gap >= 1) || (use_ext && r == 20);
      cfg_delay = (r == 0 && gap >= 1) ? 16'($urandom) : dl;
      cfg_width = (r == 0 && gap >= 1) ? 8'($urandom) : 8'(w);
      trigger = !use_ext && (r == 1 + gap || (r == 0 && noise));
      if (noise && a > t && e > t && e <= rend) begin
        arm = 1'($urandom);
        trigger = 1'($urandom);
        cfg_delay = 16'($urandom);
        cfg_width = 8'($urandom);
      end
      abort = e == a;
`ifdef MSSI_SYNC_EXT_TRIG_EN
      ext_trig = use_ext && r >= 1 && r < 45;
`endif
      @(negedge clk);
    end
    arm = 1'b0;
    trigger = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    int d0, d1, w, gap, ab;
    repeat (3) @(negedge clk);
    chk("reset outputs", int'({done, busy, armed, sync_out}), 0);
    resetn = 1'b1;
    prev = '0;
    mon_en = 1'b1;
    run_seq({8'd0, 8'd0}, 4, 0, -1, 1'b0, 1'b0);
    run_seq({8'd10, 8'd3}, 5, 1, -1, 1'b0, 1'b0);
    run_seq({8'd2, 8'd7}, 0, 2, -1, 1'b0, 1'b0);
    run_seq({8'd20, 8'd0}, 8, 0, 7, 1'b0, 1'b0);
    for (int k = 0; k < 30; k++) begin
      d0 = $urandom_range(0, 20);
      d1 = $urandom_range(0, 20);
      w = $urandom_range(0, 8);
      gap = $urandom_range(0, 3);
      ab = $urandom_range(0, 3) == 0 ? $urandom_range(1, gap + (d0 > d1 ? d0 : d1) + w + 4) : -1;
      run_seq({8'(d1), 8'(d0)}, w, gap, ab, 1'b1, 1'b0);
    end
`ifdef MSSI_SYNC_EXT_TRIG_EN
    run_seq({8'd1, 8'd1}, 2, 3, 40, 1'b0, 1'b1);
`endif
    repeat (3) @(negedge clk);
    chk("scoreboard drained", q.size(), 0);
    mon_en = 1'b0;
    cfg_delay = '0;
    cfg_width = 8'd20;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    repeat (5) @(negedge clk);
    chk("outputs before reset", int'({done, busy, armed, sync_out}), 5'b01011);
    #2 resetn = 1'b0;
    #1 chk("async reset mid-run", int'({done, busy, armed, sync_out}), 0);
    @(negedge clk);
    resetn = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
